// File: rtl/rx_ppram.sv
// Receive frame buffer pool: a ring of BUF_NUM byte buffers, one filling, the rest queued for the host.
// Optional lost-frame counter enabled by defining RX_PPRAM_LOST_CNT_EN.
module rx_ppram #(
    parameter int unsigned BUF_NUM = 2,
    parameter int unsigned ADDR_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        wr_byte,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic              wr_clk,
    input  logic [7:0]        wr_flags,
    input  logic              switch,
    input  logic              clr,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_byte,
    output logic [7:0]        rd_flags,
    output logic              rd_valid,
    input  logic              rd_done,
    output logic              rx_lost,
    output logic [7:0]        lost_cnt,
    output logic [3:0]        buf_free
);

    localparam int unsigned IDX_W    = (BUF_NUM > 1) ? $clog2(BUF_NUM) : 1;
    localparam int unsigned DEPTH    = 2 ** ADDR_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BUF_NUM - 1);

    logic [7:0] mem       [0:BUF_NUM-1][0:DEPTH-1];
    logic [7:0] flags_mem [0:BUF_NUM-1];

    logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
    logic [IDX_W-1:0] rd_idx_q, rd_idx_d;
    logic [IDX_W-1:0] ready_cnt_q, ready_cnt_d;
    logic [IDX_W-1:0] cnt_rel;
    logic [7:0]       rd_byte_q;
    logic [7:0]       rd_flags_q, rd_flags_d;
    logic             rd_valid_q;
    logic             rx_lost_q;
    logic             rel_act;
    logic             commit_ok;
    logic             commit_lost;

    function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] idx);
        return (idx == LAST_IDX) ? '0 : idx + 1'b1;
    endfunction

    always_comb begin
        rel_act     = rd_done & rd_valid_q & ~clr;
        // A release in the same cycle frees a slot the commit may take.
        cnt_rel     = ready_cnt_q - IDX_W'(rel_act);
        commit_ok   = switch & ~clr & (cnt_rel < LAST_IDX);
        commit_lost = switch & ~clr & ~(cnt_rel < LAST_IDX);

        wr_idx_d    = wr_idx_q;
        rd_idx_d    = rd_idx_q;
        ready_cnt_d = ready_cnt_q;
        if (clr) begin
            wr_idx_d    = '0;
            rd_idx_d    = '0;
            ready_cnt_d = '0;
        end else begin
            if (commit_ok) wr_idx_d = idx_inc(wr_idx_q);
            if (rel_act)   rd_idx_d = idx_inc(rd_idx_q);
            unique case ({commit_ok, rel_act})
                2'b10:   ready_cnt_d = ready_cnt_q + 1'b1;
                2'b01:   ready_cnt_d = ready_cnt_q - 1'b1;
                default: ready_cnt_d = ready_cnt_q;
            endcase
        end

        // Forward flags being committed straight into an empty queue's head.
        rd_flags_d = flags_mem[rd_idx_d];
        if (clr) begin
            rd_flags_d = 8'h00;
        end else if (commit_ok && (rd_idx_d == wr_idx_q)) begin
            rd_flags_d = wr_flags;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_idx_q    <= '0;
            rd_idx_q    <= '0;
            ready_cnt_q <= '0;
            rd_flags_q  <= 8'h00;
            rd_valid_q  <= 1'b0;
            rx_lost_q   <= 1'b0;
        end else begin
            wr_idx_q    <= wr_idx_d;
            rd_idx_q    <= rd_idx_d;
            ready_cnt_q <= ready_cnt_d;
            rd_flags_q  <= rd_flags_d;
            rd_valid_q  <= (ready_cnt_d != '0);
            rx_lost_q   <= commit_lost;
        end
    end

    // Storage arrays carry no reset.
    always_ff @(posedge clk) begin
        if (wr_clk)    mem[wr_idx_q][wr_addr] <= wr_byte;
        if (commit_ok) flags_mem[wr_idx_q]    <= wr_flags;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_byte_q <= 8'h00;
        end else begin
            rd_byte_q <= mem[rd_idx_q][rd_addr];
        end
    end

`ifdef RX_PPRAM_LOST_CNT_EN
    logic [7:0] lost_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lost_cnt_q <= 8'h00;
        end else if (clr) begin
            lost_cnt_q <= 8'h00;
        end else if (commit_lost && (lost_cnt_q != 8'hff)) begin
            lost_cnt_q <= lost_cnt_q + 8'd1;
        end
    end

    assign lost_cnt = lost_cnt_q;
`else
    assign lost_cnt = 8'h00;
`endif

    assign rd_byte  = rd_byte_q;
    assign rd_flags = rd_flags_q;
    assign rd_valid = rd_valid_q;
    assign rx_lost  = rx_lost_q;
    assign buf_free = 4'(BUF_NUM - 1) - 4'(ready_cnt_q);

endmodule

// File: tb/tb_rx_ppram.sv
// Directed bench for rx_ppram: a 2-buffer and a 4-buffer instance share one stimulus bus.
module tb_rx_ppram;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] wr_byte, wr_addr, wr_flags, rd_addr;
    logic       wr_clk, switch, clr, rd_done;

    logic [7:0] rd_byte2, rd_flags2, lost_cnt2;
    logic       rd_valid2, rx_lost2;
    logic [3:0] buf_free2;
    logic [7:0] rd_byte4, rd_flags4, lost_cnt4;
    logic       rd_valid4, rx_lost4;
    logic [3:0] buf_free4;

    int n_vec = 0;
    int n_bad = 0;

`ifdef RX_PPRAM_LOST_CNT_EN
    localparam logic [7:0] LC1 = 8'd1;
    localparam logic [7:0] LCSAT = 8'd255;
`else
    localparam logic [7:0] LC1 = 8'd0;
    localparam logic [7:0] LCSAT = 8'd0;
`endif

    always #5 clk = ~clk;

    rx_ppram #(.BUF_NUM(2), .ADDR_W(8)) dut2 (
        .clk(clk), .reset(reset), .wr_byte(wr_byte), .wr_addr(wr_addr), .wr_clk(wr_clk),
        .wr_flags(wr_flags), .switch(switch), .clr(clr), .rd_addr(rd_addr),
        .rd_byte(rd_byte2), .rd_flags(rd_flags2), .rd_valid(rd_valid2), .rd_done(rd_done),
        .rx_lost(rx_lost2), .lost_cnt(lost_cnt2), .buf_free(buf_free2)
    );

    rx_ppram #(.BUF_NUM(4), .ADDR_W(8)) dut4 (
        .clk(clk), .reset(reset), .wr_byte(wr_byte), .wr_addr(wr_addr), .wr_clk(wr_clk),
        .wr_flags(wr_flags), .switch(switch), .clr(clr), .rd_addr(rd_addr),
        .rd_byte(rd_byte4), .rd_flags(rd_flags4), .rd_valid(rd_valid4), .rd_done(rd_done),
        .rx_lost(rx_lost4), .lost_cnt(lost_cnt4), .buf_free(buf_free4)
    );

    typedef struct {
        logic       wr_clk;
        logic [7:0] wr_addr;
        logic [7:0] wr_byte;
        logic       sw;
        logic [7:0] wr_flags;
        logic       rd_done;
        logic [7:0] rd_addr;
        logic       e_valid;
        logic       c_flags;
        logic [7:0] e_flags;
        logic       c_byte;
        logic [7:0] e_byte;
        logic       e_lost;
        logic [3:0] e_free;
        logic [7:0] e_lcnt;
    } vec_t;

    vec_t tbl [0:24];

    function automatic vec_t mk(input logic wc, input logic [7:0] wa, input logic [7:0] wb,
                                input logic sw, input logic [7:0] wf, input logic rdn,
                                input logic [7:0] ra, input logic ev, input logic cf,
                                input logic [7:0] ef, input logic cb, input logic [7:0] eb,
                                input logic el, input logic [3:0] efr, input logic [7:0] elc);
        vec_t v;
        v.wr_clk = wc;  v.wr_addr = wa; v.wr_byte = wb; v.sw = sw; v.wr_flags = wf;
        v.rd_done = rdn; v.rd_addr = ra; v.e_valid = ev; v.c_flags = cf; v.e_flags = ef;
        v.c_byte = cb; v.e_byte = eb; v.e_lost = el; v.e_free = efr; v.e_lcnt = elc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %02h expected %02h", name, got, exp);
        end
    endtask

    task automatic step(input logic wc, input logic [7:0] wa, input logic [7:0] wb,
                        input logic sw, input logic [7:0] wf, input logic rdn,
                        input logic [7:0] ra, input logic cl);
        @(negedge clk);
        wr_clk = wc; wr_addr = wa; wr_byte = wb; switch = sw; wr_flags = wf;
        rd_done = rdn; rd_addr = ra; clr = cl;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    endtask

    int pulses;

    initial begin
        reset = 1'b1;
        wr_clk = 0; wr_addr = 0; wr_byte = 0; switch = 0; wr_flags = 0;
        rd_done = 0; rd_addr = 0; clr = 0;

        //           wc wa     wb     sw wf     rd ra     ev cf ef     cb eb     el fr lc
        tbl[0]  = mk(1, 8'h00, 8'h11, 0, 8'h00, 0, 8'h00, 0, 0, 8'h00, 0, 8'h00, 0, 1, 0);
        tbl[1]  = mk(1, 8'h01, 8'h12, 0, 8'h00, 0, 8'h00, 0, 0, 8'h00, 0, 8'h00, 0, 1, 0);
        tbl[2]  = mk(1, 8'h02, 8'h13, 0, 8'h00, 0, 8'h00, 0, 0, 8'h00, 0, 8'h00, 0, 1, 0);
        tbl[3]  = mk(1, 8'h03, 8'h14, 0, 8'h00, 0, 8'h00, 0, 0, 8'h00, 0, 8'h00, 0, 1, 0);
        tbl[4]  = mk(1, 8'h04, 8'h15, 0, 8'h00, 0, 8'h00, 0, 0, 8'h00, 0, 8'h00, 0, 1, 0);
        tbl[5]  = mk(0, 8'h00, 8'h00, 1, 8'h00, 0, 8'h00, 1, 1, 8'h00, 1, 8'h11, 0, 0, 0);
        tbl[6]  = mk(0, 8'h00, 8'h00, 0, 8'h00, 0, 8'h02, 1, 1, 8'h00, 1, 8'h13, 0, 0, 0);
        tbl[7]  = mk(1, 8'h00, 8'hb0, 0, 8'h00, 0, 8'h00, 1, 1, 8'h00, 1, 8'h11, 0, 0, 0);
        tbl[8]  = mk(0, 8'h00, 8'h00, 1, 8'h22, 0, 8'h00, 1, 1, 8'h00, 1, 8'h11, 1, 0, LC1);
        tbl[9]  = mk(0, 8'h00, 8'h00, 0, 8'h00, 0, 8'h00, 1, 1, 8'h00, 1, 8'h11, 0, 0, LC1);
        tbl[10] = mk(0, 8'h00, 8'h00, 0, 8'h00, 1, 8'h02, 0, 0, 8'h00, 1, 8'h13, 0, 1, LC1);
        tbl[11] = mk(1, 8'h00, 8'hc1, 0, 8'h00, 0, 8'h00, 0, 0, 8'h00, 0, 8'h00, 0, 1, LC1);
        tbl[12] = mk(0, 8'h00, 8'h00, 1, 8'h33, 0, 8'h00, 1, 1, 8'h33, 1, 8'hc1, 0, 0, LC1);
        tbl[13] = mk(0, 8'h00, 8'h00, 0, 8'h00, 0, 8'h00, 1, 1, 8'h33, 1, 8'hc1, 0, 0, LC1);
        tbl[14] = mk(0, 8'h00, 8'h00, 0, 8'h00, 1, 8'h00, 0, 0, 8'h00, 1, 8'hc1, 0, 1, LC1);
        tbl[15] = mk(1, 8'h00, 8'h70, 0, 8'h00, 0, 8'h00, 0, 0, 8'h00, 0, 8'h00, 0, 1, LC1);
        tbl[16] = mk(1, 8'h01, 8'h77, 1, 8'h07, 0, 8'h00, 1, 1, 8'h07, 1, 8'h70, 0, 0, LC1);
        tbl[17] = mk(0, 8'h00, 8'h00, 0, 8'h00, 0, 8'h01, 1, 1, 8'h07, 1, 8'h77, 0, 0, LC1);
        tbl[18] = mk(1, 8'h00, 8'h88, 0, 8'h00, 0, 8'h01, 1, 1, 8'h07, 1, 8'h77, 0, 0, LC1);
        tbl[19] = mk(0, 8'h00, 8'h00, 1, 8'h08, 1, 8'h01, 1, 1, 8'h08, 1, 8'h77, 0, 0, LC1);
        tbl[20] = mk(0, 8'h00, 8'h00, 0, 8'h00, 0, 8'h00, 1, 1, 8'h08, 1, 8'h88, 0, 0, LC1);
        tbl[21] = mk(0, 8'h00, 8'h00, 0, 8'h00, 1, 8'h00, 0, 0, 8'h00, 1, 8'h88, 0, 1, LC1);
        tbl[22] = mk(0, 8'h00, 8'h00, 0, 8'h00, 1, 8'h00, 0, 0, 8'h00, 1, 8'h70, 0, 1, LC1);
        tbl[23] = mk(0, 8'h00, 8'h00, 1, 8'h44, 0, 8'h00, 1, 1, 8'h44, 1, 8'h70, 0, 0, LC1);
        tbl[24] = mk(0, 8'h00, 8'h00, 0, 8'h00, 1, 8'h00, 0, 0, 8'h00, 1, 8'h70, 0, 1, LC1);

        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("reset rd_valid2", {7'b0, rd_valid2}, 8'h00);
        chk("reset rd_flags2", rd_flags2, 8'h00);
        chk("reset rd_byte2", rd_byte2, 8'h00);
        chk("reset rx_lost2", {7'b0, rx_lost2}, 8'h00);
        chk("reset lost_cnt2", lost_cnt2, 8'h00);
        chk("reset buf_free2", {4'b0, buf_free2}, 8'h01);
        chk("reset rd_valid4", {7'b0, rd_valid4}, 8'h00);
        chk("reset buf_free4", {4'b0, buf_free4}, 8'h03);

        // Frames through the 2-buffer pool: commit, lost commit, release, same-cycle write/switch
        // and full-pool switch with simultaneous release.
        for (int i = 0; i < 25; i++) begin
            step(tbl[i].wr_clk, tbl[i].wr_addr, tbl[i].wr_byte, tbl[i].sw, tbl[i].wr_flags,
                 tbl[i].rd_done, tbl[i].rd_addr, 1'b0);
            chk($sformatf("v%0d rd_valid", i), {7'b0, rd_valid2}, {7'b0, tbl[i].e_valid});
            chk($sformatf("v%0d rx_lost", i), {7'b0, rx_lost2}, {7'b0, tbl[i].e_lost});
            chk($sformatf("v%0d buf_free", i), {4'b0, buf_free2}, {4'b0, tbl[i].e_free});
            chk($sformatf("v%0d lost_cnt", i), lost_cnt2, tbl[i].e_lcnt);
            if (tbl[i].c_flags) chk($sformatf("v%0d rd_flags", i), rd_flags2, tbl[i].e_flags);
            if (tbl[i].c_byte) chk($sformatf("v%0d rd_byte", i), rd_byte2, tbl[i].e_byte);
        end

        // Fill the pool, then refuse 300 commits in a row.
        step(1'b0, 8'h00, 8'h00, 1'b1, 8'h66, 1'b0, 8'h00, 1'b0);
        chk("sat commit rd_valid", {7'b0, rd_valid2}, 8'h01);
        chk("sat commit rx_lost", {7'b0, rx_lost2}, 8'h00);
        pulses = 0;
        for (int i = 0; i < 300; i++) begin
            step(1'b0, 8'h00, 8'h00, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0);
            if (rx_lost2) pulses++;
        end
        idle();
        chk("sat pulses", 8'(pulses - 300), 8'h00);
        chk("sat pulse count hi", 8'(pulses >> 8), 8'h01);
        chk("sat lost_cnt", lost_cnt2, LCSAT);
        chk("sat rx_lost idle", {7'b0, rx_lost2}, 8'h00);
        chk("sat rd_flags", rd_flags2, 8'h66);

        // Reset asserted with a pending switch on a full pool.
        @(negedge clk);
        wr_clk = 1'b1; switch = 1'b1; reset = 1'b1;
        #1;
        chk("rst rx_lost2", {7'b0, rx_lost2}, 8'h00);
        chk("rst rd_valid2", {7'b0, rd_valid2}, 8'h00);
        @(posedge clk);
        #1;
        chk("rst buf_free2", {4'b0, buf_free2}, 8'h01);
        chk("rst lost_cnt2", lost_cnt2, 8'h00);
        chk("rst rx_lost2 edge", {7'b0, rx_lost2}, 8'h00);
        @(negedge clk);
        reset = 1'b0; wr_clk = 1'b0; switch = 1'b0;

        // 4-buffer pool: three frames queued, one refused, then clr with rd_done.
        for (int f = 0; f < 3; f++) begin
            step(1'b1, 8'h00, 8'(8'ha0 + f), 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
            step(1'b0, 8'h00, 8'h00, 1'b1, 8'(f + 1), 1'b0, 8'h00, 1'b0);
        end
        chk("q3 rd_valid4", {7'b0, rd_valid4}, 8'h01);
        chk("q3 rd_flags4", rd_flags4, 8'h01);
        chk("q3 buf_free4", {4'b0, buf_free4}, 8'h00);
        step(1'b0, 8'h00, 8'h00, 1'b1, 8'h99, 1'b0, 8'h00, 1'b0);
        chk("q3 lost rx_lost4", {7'b0, rx_lost4}, 8'h01);
        chk("q3 lost lost_cnt4", lost_cnt4, LC1);
        chk("q3 lost rd_flags4", rd_flags4, 8'h01);
        step(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b1, 8'h00, 1'b1);
        chk("clr rd_valid4", {7'b0, rd_valid4}, 8'h00);
        chk("clr buf_free4", {4'b0, buf_free4}, 8'h03);
        chk("clr lost_cnt4", lost_cnt4, 8'h00);
        step(1'b1, 8'h00, 8'hd5, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        step(1'b0, 8'h00, 8'h00, 1'b1, 8'h55, 1'b0, 8'h00, 1'b0);
        chk("post clr rd_valid4", {7'b0, rd_valid4}, 8'h01);
        chk("post clr rd_flags4", rd_flags4, 8'h55);
        chk("post clr buf_free4", {4'b0, buf_free4}, 8'h02);
        step(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        chk("post clr rd_byte4", rd_byte4, 8'hd5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
